// File: rtl/serial_add_sequencer.sv
// Bit-serial operand feeder and sum/carry collector around an external 1-bit full adder.
// Optional subtract mode (A-B via ~B and carry-in 1) when SERIAL_ADD_SUB_EN is defined.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load = sub ? ~op_b : op_b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = op_b;
  assign w_c_load = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= op_a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= {fa_sum, r_result[WIDTH-1:1]};
          r_carry  <= fa_cout;
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_cout  <= fa_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          // A start seen while done is high reloads directly for back-to-back runs.
          if (start) begin
            r_a_sr  <= op_a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fa_a   = r_busy & r_a_sr[0];
  assign fa_b   = r_busy & r_b_sr[0];
  assign fa_cin = r_busy & r_carry;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;

endmodule
